jtframe_rom_arb: RTL
====================

Name: jtframe_rom_arb

Overview:
- Shares the single SDRAM read port of the board/SDRAM controller (sdram_req/sdram_ack/sdram_addr/data_read/data_rdy) among SLOTS game-side ROM requesters (main CPU, sound CPU, char, scroll, objects).
- Each slot has a one-entry tag/data cache. Hits complete without SDRAM traffic; misses are arbitrated and sequenced one at a time.
- Sits between the game core and the board's SDRAM controller, in the clk_rom domain.

Parameters:
- SLOTS, 4: number of requesters, 2..8. Slot 0 has the highest fixed priority.
- AW, 22: word address width, matching sdram_addr.
- DW, 32: data width, matching data_read.

Ports:
- clk_rom  in  1  ROM/SDRAM clock.
- rst  in  1  Reset. Asynchronous, active-high.
- downloading  in  1  ROM load in progress. Holds the arbiter idle and invalidates all slot caches.
- loop_rst  in  1  SDRAM controller init/refresh-loop reset. Same effect as downloading.
- slot_cs  in  SLOTS  Per-slot request enable.
- slot_addr  in  SLOTS*AW  Per-slot word addresses, flattened. Slot i is at [i*AW +: AW].
- slot_ok  out  SLOTS  Per-slot data valid for the current slot_addr.
- slot_dout  out  SLOTS*DW  Per-slot cached data, flattened.
- sdram_req  out  1  Request to the SDRAM controller.
- sdram_addr  out  AW  Address of the granted request.
- sdram_ack  in  1  Controller accepted the request (1-cycle pulse).
- data_read  in  DW  SDRAM read data.
- data_rdy  in  1  data_read valid (1-cycle pulse).

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0. All tag-valid bits=0. State=IDLE, grant=0.
- Hit, per slot (combinational): hit_i = valid_i & (tag_i == slot_addr_i). slot_ok_i = slot_cs_i & hit_i. slot_dout_i always drives data_i.
- Miss: miss_i = slot_cs_i & ~hit_i.
- FSM state IDLE: if any miss_i and neither downloading nor loop_rst is high, select the winner (lowest index). Register grant=i, sdram_addr=slot_addr_i, sdram_req=1. Go to WAIT_ACK.
- FSM state WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, drop sdram_req next edge and go to WAIT_DATA.
- FSM state WAIT_DATA: on data_rdy, write data_grant<=data_read, tag_grant<=sdram_addr, valid_grant<=1. Return to IDLE.
- Latency: minimum 1 cycle from miss to sdram_req. slot_ok rises the cycle after data_rdy (registered tag/data, combinational compare).
- Back-to-back: a new grant may be issued in the IDLE cycle directly after the WAIT_DATA exit. No dead cycle beyond that IDLE cycle.
- Address change mid-transaction: the transaction completes and fills the cache with the old address. slot_ok stays 0 for the new address, and the miss is re-arbitrated in the next IDLE.
- slot_cs dropped mid-transaction: the transaction still completes and fills the cache. The SDRAM handshake is never abandoned.
- data_rdy in the same cycle as sdram_ack: treated as ack followed by data. The fill occurs and the FSM goes to IDLE.
- data_rdy or sdram_ack outside its expected state: ignored.
- downloading or loop_rst high in any state: synchronously sdram_req=0, all valid=0, state=IDLE. slot_dout keeps its value, but slot_ok=0 because valid=0.
- Simultaneous misses: one grant per IDLE cycle, chosen by the priority rule. No slot starves under fixed priority unless a higher slot misses continuously.

Optional Feature:
- Macro JTFRAME_ROMARB_RR_EN.
- Defined: round-robin priority. The search starts at (last_grant+1) mod SLOTS, with last_grant reset to SLOTS-1. Any continuously missing slot is granted within SLOTS transactions.
- Undefined: fixed priority, slot 0 highest, no last_grant register.

Decomposition:
- Package jtframe_romarb_pkg: state enum {IDLE, WAIT_ACK, WAIT_DATA} and a localparam for the grant index width, $clog2(SLOTS).
- One natural sub-module: jtframe_romarb_slot, holding per-slot tag/valid/data registers, hit compare, miss output and fill/invalidate inputs. Instantiated SLOTS times via generate.
- Priority selection and FSM stay in the top module.

Test Plan:
- Single miss: slot 1 cs=1, addr=0x00123. sdram_req=1 with sdram_addr=0x00123 on the next cycle. ack after 2 cycles, data_rdy with 0xDEADBEEF after 3 more. slot_ok[1]=1 and slot_dout[1]=0xDEADBEEF the cycle after data_rdy.
- Hit: repeat addr 0x00123 on slot 1. slot_ok[1]=1 immediately, and sdram_req stays 0.
- Contention: slots 0, 2, 3 miss together. Fixed priority serves 0, 2, 3 in order. With JTFRAME_ROMARB_RR_EN and last_grant=2, the order is 3, 0, 2.
- Address change in WAIT_DATA: slot 2 moves from 0x10 to 0x20. Fill tags 0x10, slot_ok[2] stays 0, and a second request is issued with sdram_addr=0x20.
- Abort: assert downloading during WAIT_ACK. sdram_req=0 the next cycle, every slot_ok=0, state IDLE. After downloading falls, previously cached addresses miss again.
- Async reset: assert rst mid-WAIT_DATA between clock edges. Outputs clear immediately without a clock edge, and a subsequent data_rdy is ignored.

Source files
------------

// File: rtl/jtframe_romarb_pkg.sv
// Shared types for the ROM arbiter.
// FSM state encoding and grant index sizing.
package jtframe_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    localparam int SLOTS_DEF = 4;
    localparam int GW_DEF    = $clog2(SLOTS_DEF);

    // Grant index width, never below one bit
    function automatic int grant_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One-entry tag/data cache for a single ROM requester.
// Hit compare is combinational against the registered tag.
import jtframe_romarb_pkg::*;

module jtframe_romarb_slot #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          inval,
    output logic          ok,
    output logic          miss,
    output logic [DW-1:0] dout
);

    logic          valid;
    logic [AW-1:0] tag;
    logic          hit;

    // Tag/data storage; invalidate wins over a fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            dout  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            dout  <= fill_data;
        end
    end

    // Hit/miss decode for the current address
    always_comb begin
        hit  = valid && (tag == addr);
        ok   = cs && hit;
        miss = cs && !hit;
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// SDRAM read-port arbiter with a one-entry cache per slot.
// JTFRAME_ROMARB_RR_EN selects round-robin instead of fixed priority.
import jtframe_romarb_pkg::*;

module jtframe_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic             clk_rom,
    input  logic             rst,
    input  logic             downloading,
    input  logic             loop_rst,
    input  logic [SLOTS-1:0] slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0] slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic             sdram_req,
    output logic [AW-1:0]    sdram_addr,
    input  logic             sdram_ack,
    input  logic [DW-1:0]    data_read,
    input  logic             data_rdy
);

    localparam int GW = grant_w(SLOTS);

    state_t          state, state_nx;
    logic [GW-1:0]   grant, grant_nx;
    logic [GW-1:0]   win;
    logic            any_miss;
    logic            req_nx;
    logic [AW-1:0]   addr_nx;
    logic            fill;
    logic            inval;
    logic [SLOTS-1:0] miss;
    logic [AW-1:0]   addr_a [SLOTS];

    assign inval = downloading | loop_rst;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign addr_a[i] = slot_addr[i*AW +: AW];

        jtframe_romarb_slot #(
            .AW (AW),
            .DW (DW)
        ) u_slot (
            .clk       (clk_rom),
            .rst       (rst),
            .cs        (slot_cs[i]),
            .addr      (addr_a[i]),
            .fill      (fill && (grant == GW'(i))),
            .fill_addr (sdram_addr),
            .fill_data (data_read),
            .inval     (inval),
            .ok        (slot_ok[i]),
            .miss      (miss[i]),
            .dout      (slot_dout[i*DW +: DW])
        );
    end

`ifdef JTFRAME_ROMARB_RR_EN
    localparam logic [GW-1:0] LG_RST = GW'(SLOTS-1);
    logic [GW-1:0] last_grant;

    // Remember the most recent grant to rotate the search start
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst)
            last_grant <= LG_RST;
        else if (state == IDLE && any_miss && !inval)
            last_grant <= win;
    end

    // Round-robin pick starting just after the last grant
    always_comb begin
        int idx;
        idx      = 0;
        any_miss = 1'b0;
        win      = '0;
        for (int k = SLOTS-1; k >= 0; k--) begin
            idx = (int'(last_grant) + 1 + k) % SLOTS;
            if (miss[idx]) begin
                any_miss = 1'b1;
                win      = idx[GW-1:0];
            end
        end
    end
`else
    // Fixed priority pick, lowest index wins
    always_comb begin
        any_miss = 1'b0;
        win      = '0;
        for (int i = SLOTS-1; i >= 0; i--) begin
            if (miss[i]) begin
                any_miss = 1'b1;
                win      = i[GW-1:0];
            end
        end
    end
`endif

    // Request sequencer registers
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
        end
    end

    // Next-state, request and fill decode
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        req_nx   = sdram_req;
        addr_nx  = sdram_addr;
        fill     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_miss) begin
                    grant_nx = win;
                    addr_nx  = addr_a[win];
                    req_nx   = 1'b1;
                    state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nx = 1'b0;
                    if (data_rdy) begin
                        fill     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (inval) begin
            state_nx = IDLE;
            grant_nx = grant;
            req_nx   = 1'b0;
            addr_nx  = sdram_addr;
            fill     = 1'b0;
        end
    end

endmodule
